// File: rtl/dmem_pkg.sv
// Shared types and address decoding for the data-memory responder.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    typedef struct packed {
        logic [9:0] index;
        logic       error;
    } addr_dec_t;

    // Misaligned or out-of-range addresses are both errors; the range check is full 32-bit unsigned.
    function automatic addr_dec_t decode_addr(input logic [31:0] addr, input int unsigned depth);
        addr_dec_t d;
        d.index = addr[11:2];
        d.error = (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(depth));
        return d;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM with registered read data; contents are never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic              clock,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     index,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Read data only moves on a load, so it stays stable while a response is held.
    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                mem_q[index] <= wdata;
            end else begin
                rdata_q <= mem_q[index];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Latency-configurable data memory behind a valid/ready request/response handshake.
//   state     | meaning
//   ST_IDLE   | ready for a request
//   ST_WAIT   | counting down LATENCY wait cycles
//   ST_ACCESS | captured request executes at the exiting edge
//   ST_RESP   | response held until the CPU takes it
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_address,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_error
);

    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  LAT4 = 4'(LATENCY);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              resp_err_q, resp_err_d;
    logic              rd_ok_q, rd_ok_d;

    addr_dec_t         dec;
    logic              unused_idx_hi;
    logic              accept;
    logic              ram_en;
    logic [WORD_W-1:0] ram_rdata;

    assign dec           = decode_addr(req_address, DEPTH);
    assign unused_idx_hi = ^dec.index;

    // Ready is held low for as long as reset is asserted, even though the state is already IDLE.
    assign req_ready  = (state_q == ST_IDLE) && !reset;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_error = resp_err_q;
    assign resp_rdata = (resp_valid && rd_ok_q) ? ram_rdata : '0;
    assign ram_en     = (state_q == ST_ACCESS) && !err_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        err_d      = err_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        resp_err_d = resp_err_q;
        rd_ok_d    = rd_ok_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    wr_d    = req_write;
                    err_d   = dec.error;
                    idx_d   = dec.index[AW-1:0];
                    wdata_d = req_wdata;
                    cnt_d   = LAT4;
                    state_d = (LATENCY == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                resp_err_d = err_q;
                rd_ok_d    = !wr_q && !err_q;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_err_d = 1'b0;
                    rd_ok_d    = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            resp_err_q <= 1'b0;
            rd_ok_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            err_q      <= err_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            resp_err_q <= resp_err_d;
            rd_ok_q    <= rd_ok_d;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clock (clock),
        .en    (ram_en),
        .we    (wr_q),
        .index (idx_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

endmodule
